// File: rtl/key_event_pkg.sv
// key_event_pkg: shared types and helpers for the key event unit.
//   kev_state_t : per-channel classification FSM states
//   kev_cnt_w   : counter width that can hold 0..max(a,b)-1
package key_event_pkg;

    typedef enum logic [1:0] {
        KEV_IDLE = 2'd0,
        KEV_HELD = 2'd1,
        KEV_LONG = 2'd2
    } kev_state_t;

    function automatic int kev_cnt_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/key_event_if.sv
// key_event_if: raw key inputs and classified event outputs of the key
// event unit, one bit per channel.
//   i_in      raw key levels (driven by the pin side / master)
//   o_level   debounced level, 1 = pressed
//   o_press, o_release, o_short, o_long, o_repeat : 1-cycle event pulses
// Modports: master = pin/consumer side, slave = key_event_unit.
interface key_event_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] i_in;
    logic [N_KEYS-1:0] o_level;
    logic [N_KEYS-1:0] o_press;
    logic [N_KEYS-1:0] o_release;
    logic [N_KEYS-1:0] o_short;
    logic [N_KEYS-1:0] o_long;
    logic [N_KEYS-1:0] o_repeat;

    modport master (
        output i_in,
        input  o_level, o_press, o_release, o_short, o_long, o_repeat
    );

    modport slave (
        input  i_in,
        output o_level, o_press, o_release, o_short, o_long, o_repeat
    );
endinterface

// File: rtl/key_event_chan.sv
// key_event_chan: one key channel. Two-flop synchroniser, debounce counter,
// IDLE/HELD/LONG classifier and registered one-cycle event pulses.
// Optional feature: KEY_EVENT_REPEAT_EN enables auto-repeat in KEV_LONG;
// without it o_repeat is 0 and the hold counter idles in KEV_LONG.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_key          raw key level, already normalised (1 = pressed)
//   o_level        debounced level
//   o_press/o_release/o_short/o_long/o_repeat  event pulses
module key_event_chan
    import key_event_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int LONG_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_short,
    output logic o_long,
    output logic o_repeat
);

    localparam int DW = kev_cnt_w(DEBOUNCE_CYCLES, DEBOUNCE_CYCLES);
    localparam int CW = kev_cnt_w(LONG_CYCLES, REPEAT_CYCLES);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LONG_MAX = CW'(LONG_CYCLES - 1);
`ifdef KEY_EVENT_REPEAT_EN
    localparam logic [CW-1:0] REP_MAX  = CW'(REPEAT_CYCLES - 1);
`endif

    logic [1:0]    sync_q;
    logic [DW-1:0] deb_q, deb_d;
    logic          stab_q, stab_d;   // debounced level inside the channel
    logic          lvl_q;            // stab_q delayed so o_level lines up with the pulses
    kev_state_t    state_q, state_d;
    logic [CW-1:0] hold_q, hold_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          short_q, short_d;
    logic          long_q, long_d;
    logic          rise_w, fall_w;
`ifdef KEY_EVENT_REPEAT_EN
    logic          rpt_q, rpt_d;
`endif

    // Debounce: count consecutive samples that disagree with the accepted
    // level; the DEBOUNCE_CYCLES-th disagreeing sample flips it.
    always_comb begin
        deb_d  = '0;
        stab_d = stab_q;
        if (sync_q[1] != stab_q) begin
            if (deb_q == DEB_MAX) begin
                stab_d = ~stab_q;
            end else begin
                deb_d = deb_q + 1'b1;
            end
        end
    end

    assign rise_w = stab_q & ~lvl_q;
    assign fall_w = ~stab_q & lvl_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        short_d = 1'b0;
        long_d  = 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
        rpt_d   = 1'b0;
`endif
        case (state_q)
            KEV_IDLE: begin
                if (rise_w) begin
                    state_d = KEV_HELD;
                    hold_d  = '0;
                    press_d = 1'b1;
                end
            end
            KEV_HELD: begin
                // Release takes priority over reaching the long threshold.
                if (fall_w) begin
                    state_d = KEV_IDLE;
                    rel_d   = 1'b1;
                    short_d = 1'b1;
                end else if (hold_q == LONG_MAX) begin
                    state_d = KEV_LONG;
                    hold_d  = '0;
                    long_d  = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            KEV_LONG: begin
                if (fall_w) begin
                    state_d = KEV_IDLE;
                    rel_d   = 1'b1;
`ifdef KEY_EVENT_REPEAT_EN
                end else if (hold_q == REP_MAX) begin
                    hold_d = '0;
                    rpt_d  = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
`endif
                end
            end
            default: state_d = KEV_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q  <= '0;
            deb_q   <= '0;
            stab_q  <= 1'b0;
            lvl_q   <= 1'b0;
            state_q <= KEV_IDLE;
            hold_q  <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], i_key};
            deb_q   <= deb_d;
            stab_q  <= stab_d;
            lvl_q   <= stab_q;
            state_q <= state_d;
            hold_q  <= hold_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            short_q <= short_d;
            long_q  <= long_d;
        end
    end

`ifdef KEY_EVENT_REPEAT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) rpt_q <= 1'b0;
        else       rpt_q <= rpt_d;
    end
    assign o_repeat = rpt_q;
`else
    assign o_repeat = 1'b0;
`endif

    assign o_level   = lvl_q;
    assign o_press   = press_q;
    assign o_release = rel_q;
    assign o_short   = short_q;
    assign o_long    = long_q;

endmodule

// File: rtl/key_event_unit.sv
// key_event_unit: N_KEYS independent key channels. Normalises raw input
// polarity (ACTIVE_LOW) and instantiates one key_event_chan per key.
// Optional feature: KEY_EVENT_REPEAT_EN (auto-repeat pulses on o_repeat).
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   kif            key_event_if.slave: i_in raw levels in, o_* outputs
module key_event_unit
    import key_event_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int LONG_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    key_event_if.slave  kif
);

    logic [N_KEYS-1:0] key_w;
    logic [N_KEYS-1:0] lvl_w, press_w, rel_w, short_w, long_w, rpt_w;

    assign key_w = (ACTIVE_LOW != 0) ? ~kif.i_in : kif.i_in;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
        key_event_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_chan (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_key     (key_w[g]),
            .o_level   (lvl_w[g]),
            .o_press   (press_w[g]),
            .o_release (rel_w[g]),
            .o_short   (short_w[g]),
            .o_long    (long_w[g]),
            .o_repeat  (rpt_w[g])
        );
    end

    assign kif.o_level   = lvl_w;
    assign kif.o_press   = press_w;
    assign kif.o_release = rel_w;
    assign kif.o_short   = short_w;
    assign kif.o_long    = long_w;
    assign kif.o_repeat  = rpt_w;

endmodule

// File: tb/tb_key_event_unit.sv
// tb_key_event_unit: directed stimulus with an event scoreboard. Each
// stimulus step schedules the pulses it must cause (absolute cycle numbers)
// and a negedge monitor compares every output vector every cycle.
module tb_key_event_unit;
    import key_event_pkg::*;

    localparam int NK  = 2;
    localparam int DEB = 4;
    localparam int LNG = 20;
    localparam int REP = 5;
    localparam int LAT = DEB + 3;   // drive (after edge E) -> pulse at edge E+LAT

    localparam int K_PRESS = 0, K_REL = 1, K_SHORT = 2, K_LONG = 3, K_RPT = 4;

    typedef struct {
        int cyc;
        int kind;
        int ch;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic rst_s = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  q[$];
    logic [NK-1:0] lvl_m = '0;
    logic [NK-1:0] e_p, e_r, e_s, e_l, e_rp;

    always #5 clk = ~clk;

    key_event_if #(.N_KEYS(NK)) kif ();

    key_event_unit #(
        .N_KEYS          (NK),
        .ACTIVE_LOW      (1),
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LNG),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .kif   (kif)
    );

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= rst;
    end

    task automatic chk(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    function automatic void push_ev(input int c, input int k, input int ch);
        ev_t e;
        int  i;
        e.cyc  = c;
        e.kind = k;
        e.ch   = ch;
        i = 0;
        while (i < q.size() && q[i].cyc <= c) i++;
        q.insert(i, e);
    endfunction

    // Monitor: outputs of edge `cyc` are compared against scheduled events.
    always @(negedge clk) begin
        ev_t ev;
        e_p = '0; e_r = '0; e_s = '0; e_l = '0; e_rp = '0;
        if (rst_s) lvl_m = '0;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            ev = q.pop_front();
            checks++;
            assert (ev.cyc == cyc) else begin
                errors++;
                $error("FAIL stale_event kind=%0d ch=%0d observed_cyc=%0d expected_cyc=%0d",
                       ev.kind, ev.ch, cyc, ev.cyc);
            end
            case (ev.kind)
                K_PRESS: begin e_p[ev.ch]  = 1'b1; lvl_m[ev.ch] = 1'b1; end
                K_REL:   begin e_r[ev.ch]  = 1'b1; lvl_m[ev.ch] = 1'b0; end
                K_SHORT: e_s[ev.ch]  = 1'b1;
                K_LONG:  e_l[ev.ch]  = 1'b1;
                default: e_rp[ev.ch] = 1'b1;
            endcase
        end
        chk("level",   kif.o_level,   lvl_m);
        chk("press",   kif.o_press,   e_p);
        chk("release", kif.o_release, e_r);
        chk("short",   kif.o_short,   e_s);
        chk("long",    kif.o_long,    e_l);
        chk("repeat",  kif.o_repeat,  e_rp);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int p;
        int r;

        // Reset with both keys held; both accepted after debounce latency.
        rst = 1'b1;
        kif.i_in = 2'b00;
        step(3);
        rst = 1'b0;
        push_ev(cyc + LAT, K_PRESS, 0);
        push_ev(cyc + LAT, K_PRESS, 1);
        step(10);
        kif.i_in = 2'b11;
        push_ev(cyc + LAT, K_REL, 0);   push_ev(cyc + LAT, K_SHORT, 0);
        push_ev(cyc + LAT, K_REL, 1);   push_ev(cyc + LAT, K_SHORT, 1);
        step(12);

        // Glitch of DEB-1 samples: nothing happens.
        kif.i_in[0] = 1'b0;
        step(DEB - 1);
        kif.i_in[0] = 1'b1;
        step(10);

        // Short press on channel 0.
        kif.i_in[0] = 1'b0;
        push_ev(cyc + LAT, K_PRESS, 0);
        step(10);
        kif.i_in[0] = 1'b1;
        push_ev(cyc + LAT, K_REL, 0);
        push_ev(cyc + LAT, K_SHORT, 0);
        step(12);

        // Long hold on channel 1: long, repeats (if enabled), release without short.
        kif.i_in[1] = 1'b0;
        p = cyc + LAT;
        push_ev(p, K_PRESS, 1);
        push_ev(p + LNG, K_LONG, 1);
        step(40 + LAT);
        kif.i_in[1] = 1'b1;
        r = cyc + LAT;
        push_ev(r, K_REL, 1);
`ifdef KEY_EVENT_REPEAT_EN
        for (int t = p + LNG + REP; t < r; t += REP) push_ev(t, K_RPT, 1);
`endif
        step(12);

        // Release lands on hold count LONG-1: release wins, short fires.
        kif.i_in[0] = 1'b0;
        p = cyc + LAT;
        push_ev(p, K_PRESS, 0);
        step(LNG);
        kif.i_in[0] = 1'b1;
        push_ev(p + LNG, K_REL, 0);
        push_ev(p + LNG, K_SHORT, 0);
        step(12);

        // One cycle later: long fires, then release without short.
        kif.i_in[0] = 1'b0;
        p = cyc + LAT;
        push_ev(p, K_PRESS, 0);
        step(LNG + 1);
        kif.i_in[0] = 1'b1;
        push_ev(p + LNG, K_LONG, 0);
        push_ev(p + LNG + 1, K_REL, 0);
        step(12);

        // Reset mid-hold: state discarded, no release pulse.
        kif.i_in[1] = 1'b0;
        push_ev(cyc + LAT, K_PRESS, 1);
        step(15);
        rst = 1'b1;
        kif.i_in = 2'b11;
        step(2);
        rst = 1'b0;
        step(15);

        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL pending_events observed=%0d expected=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
